// File: rtl/csa_add_arbiter_pkg.sv
// Shared types and constants for the CSA adder arbiter.
// Holds operand widths, the clog2 helper and the output-slot state type.
package csa_arb_pkg;

    localparam int CSA_W = 32;
    localparam int SUM_W = 33;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/csa_add_arbiter_csa.sv
// 32-bit square-root carry-select adder, block widths 2,2,3,4,5,7,9.
// Each block precomputes both carry-in cases; the chain only muxes.
module SquareRootCSA
    import csa_arb_pkg::*;
(
    output logic [SUM_W-1:0] sout,
    input  logic [CSA_W-1:0] in1,
    input  logic [CSA_W-1:0] in2,
    input  logic             c0
);

    localparam int NB = 7;

    function automatic int blk_lo(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            2:       return 4;
            3:       return 7;
            4:       return 11;
            5:       return 16;
            6:       return 23;
            default: return 32;
        endcase
    endfunction

    logic [NB:0] c;

    assign c[0] = c0;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int LO = blk_lo(k);
        localparam int W  = blk_lo(k + 1) - LO;

        logic [W:0] s0;
        logic [W:0] s1;

        assign s0 = {1'b0, in1[LO+:W]} + {1'b0, in2[LO+:W]};
        assign s1 = {1'b0, in1[LO+:W]} + {1'b0, in2[LO+:W]}
                  + {{W{1'b0}}, 1'b1};

        assign sout[LO+:W] = c[k] ? s1[W-1:0] : s0[W-1:0];
        assign c[k+1]      = c[k] ? s1[W] : s0[W];
    end

    assign sout[SUM_W-1] = c[NB];

endmodule

// File: rtl/csa_add_arbiter_rr.sv
// Round-robin grant: first valid requester at or above ptr, with wrap.
// Also returns the winner index and the pointer value that follows it.
module rr_arbiter
    import csa_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] win,
    output logic [PW-1:0] nxt,
    output logic          any
);

    int idx;

    // Scan upward from ptr and stop at the first valid requester.
    always_comb begin
        grant = '0;
        win   = '0;
        any   = 1'b0;
        idx   = 0;
        for (int o = 0; o < N; o++) begin
            idx = (int'(ptr) + o) % N;
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                win        = PW'(idx);
            end
        end
    end

    // Pointer moves one past the winner so it gets lowest priority next.
    always_comb begin
        nxt = (int'(win) == N - 1) ? '0 : win + PW'(1);
    end

endmodule

// File: rtl/csa_add_arbiter.sv
// Round-robin sharing of one SquareRootCSA with a one-entry result slot.
// Define CSA_ARB_OVF_EN to add the registered signed-overflow flag res_ovf.
module csa_add_arbiter
    import csa_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [32*NREQ-1:0]    req_a,
    input  logic [32*NREQ-1:0]    req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [SUM_W-1:0]      res_sum,
    output logic [IDW-1:0]        res_id,
`ifdef CSA_ARB_OVF_EN
    output logic                  res_ovf,
`endif
    output logic                  busy
);

    state_t state;
    state_t state_next;

    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   ptr_nxt;
    logic             any_req;
    logic             slot_free;
    logic             accept;
    logic [CSA_W-1:0] a_sel;
    logic [CSA_W-1:0] b_sel;
    logic             cin_sel;
    logic [SUM_W-1:0] sum_w;

    rr_arbiter #(
        .N  (NREQ),
        .PW (IDW)
    ) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .win   (win),
        .nxt   (ptr_nxt),
        .any   (any_req)
    );

    // Operand mux driven by the round-robin winner.
    always_comb begin
        a_sel   = req_a[int'(win)*CSA_W +: CSA_W];
        b_sel   = req_b[int'(win)*CSA_W +: CSA_W];
        cin_sel = req_cin[win];
    end

    SquareRootCSA u_csa (
        .sout (sum_w),
        .in1  (a_sel),
        .in2  (b_sel),
        .c0   (cin_sel)
    );

    // Output-slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // Slot stays full on accept or while the consumer stalls.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: state_next = accept ? FULL : EMPTY;
            FULL:  state_next = (accept || !res_ready) ? FULL : EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs derived from slot state and arbitration.
    always_comb begin
        res_valid = (state == FULL);
        slot_free = !res_valid || res_ready;
        accept    = slot_free && any_req;
        req_ready = slot_free ? grant : '0;
        busy      = res_valid || (|req_valid);
    end

    // Round-robin pointer advances only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr_ptr <= '0;
        else if (accept) rr_ptr <= ptr_nxt;
    end

    // Result register loads the adder output and the winner tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum <= '0;
            res_id  <= '0;
        end else if (accept) begin
            res_sum <= sum_w;
            res_id  <= win;
        end
    end

`ifdef CSA_ARB_OVF_EN
    // Signed overflow: like-signed operands yielding an opposite-sign sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_ovf <= 1'b0;
        else if (accept)
            res_ovf <= (a_sel[31] == b_sel[31]) && (sum_w[31] != a_sel[31]);
    end
`endif

endmodule

// File: tb/tb_csa_add_arbiter.sv
// Directed bench for csa_add_arbiter with NREQ=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_csa_add_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_cin;
    logic         res_valid;
    logic         res_ready;
    logic [32:0]  res_sum;
    logic [1:0]   res_id;
    logic         busy;
`ifdef CSA_ARB_OVF_EN
    logic         res_ovf;
`endif

    int checks;
    int failures;

    csa_add_arbiter #(
        .NREQ (4),
        .IDW  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
`ifdef CSA_ARB_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic c);
        req_valid[i]   = 1'b1;
        req_a[32*i+:32] = a;
        req_b[32*i+:32] = b;
        req_cin[i]     = c;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_res(input string tag, input logic v,
                           input logic [32:0] s, input logic [1:0] id);
        chk({tag, "_valid"}, 64'(res_valid), 64'(v));
        chk({tag, "_sum"},   64'(res_sum),   64'(s));
        chk({tag, "_id"},    64'(res_id),    64'(id));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        res_ready = 1'b0;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'd2, 1'b0);

        // reset with every requester valid
        #2;
        chk_res("rst_early", 1'b0, 33'h0, 2'd0);
        tick();
        tick();
        chk_res("rst_hold", 1'b0, 33'h0, 2'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h1);
        chk("rst_busy",  64'(busy), 64'h1);

        // first accept, then backpressure for three cycles
        tick();
        chk_res("first", 1'b1, 33'h3, 2'd0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", 64'(req_ready), 64'h0);
            chk_res("bp", 1'b1, 33'h3, 2'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'h2);
        tick();
        chk_res("bp_next", 1'b1, 33'h4, 2'd1);

        // drain without accept holds the data
        req_valid = 4'b0000;
        #1;
        chk("drain_ready", 64'(req_ready), 64'h0);
        tick();
        chk_res("drain", 1'b0, 33'h4, 2'd1);
        chk("idle_busy", 64'(busy), 64'h0);

        // single add with full carry propagation
        set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b1);
        #1;
        chk("single_ready", 64'(req_ready), 64'h4);
        tick();
        chk_res("single", 1'b1, 33'h1_0000_0001, 2'd2);
        req_valid = 4'b0000;
        tick();

        // mixed-digit add from requester 3
        set_req(3, 32'h1234_5678, 32'h0FED_CBA9, 1'b0);
        #1;
        chk("r3_ready", 64'(req_ready), 64'h8);
        tick();
        chk_res("r3", 1'b1, 33'h0_2222_2221, 2'd3);

        // pointer wrapped to 0; requester 1 wins, back-to-back
        req_valid = 4'b0000;
        set_req(1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        #1;
        chk("wrap_ready", 64'(req_ready), 64'h2);
        tick();
        chk_res("wrap", 1'b1, 33'h1_0000_0000, 2'd1);
        req_valid = 4'b0000;
        tick();

        // reset while a result is pending
        set_req(0, 32'd5, 32'd5, 1'b0);
        tick();
        chk_res("pre_rst", 1'b1, 33'hA, 2'd0);
        req_valid = 4'b0000;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk_res("mid_rst", 1'b0, 33'h0, 2'd0);
        tick();
        rst_n = 1'b1;

        // round-robin with all requesters valid
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'd2, 1'b0);
        res_ready = 1'b1;
        #1;
        chk("rr_ready0", 64'(req_ready), 64'h1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_res("rr", 1'b1, 33'((k % 4) + 3), 2'(k % 4));
        end

        // drain and accept in the same cycle
        req_valid = 4'b0000;
        set_req(0, 32'd2, 32'd3, 1'b0);
        tick();
        chk_res("da_first", 1'b1, 33'h5, 2'd0);
        req_valid = 4'b0000;
        set_req(1, 32'd7, 32'd8, 1'b0);
        #1;
        chk("da_ready", 64'(req_ready), 64'h2);
        tick();
        chk_res("da_second", 1'b1, 33'hF, 2'd1);
        req_valid = 4'b0000;
        tick();
        chk("da_drained", 64'(res_valid), 64'h0);

`ifdef CSA_ARB_OVF_EN
        // signed overflow flag
        set_req(2, 32'h7FFF_FFFF, 32'h1, 1'b0);
        tick();
        chk_res("ovf", 1'b1, 33'h0_8000_0000, 2'd2);
        chk("ovf_flag", 64'(res_ovf), 64'h1);
        req_valid = 4'b0000;
        set_req(3, 32'h1, 32'h1, 1'b0);
        tick();
        chk("ovf_clear", 64'(res_ovf), 64'h0);
        req_valid = 4'b0000;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csa_add_arbiter.md
# csa_add_arbiter

Round-robin scheduler that shares one 32-bit square-root carry-select adder (SquareRootCSA) among NREQ requesters. Each requester offers an operand pair and carry-in over a valid/ready handshake. The block grants one requester per cycle, drives the shared adder and captures the 33-bit result in a single-entry output register tagged with the requester index. It sits between the requesting datapath units and the single adder instance, with registered input-to-result latency.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- IDW, default 2: requester index width, equal to clog2(NREQ).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  32*NREQ  operand A, flattened; requester i occupies bits [32i+31:32i].
- req_b  input  32*NREQ  operand B, flattened the same way.
- req_cin  input  NREQ  per-requester carry-in.
- res_valid  output  1  result register holds a result.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  33  {carry-out, sum[31:0]}.
- res_id  output  IDW  index of the requester that produced res_sum.
- busy  output  1  equals res_valid or any req_valid.

## Operation
- Two states, from res_valid:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- slot_free = ~res_valid | res_ready.
- Arbitration is combinational. The winner is the first i with req_valid[i]=1, searching upward from rr_ptr with wrap-around. req_ready[winner] = slot_free; all other req_ready bits are 0.
- Accept event = slot_free and any req_valid.
- On accept:
  - The winner's req_a, req_b and req_cin are muxed into the adder.
  - The adder output is written to res_sum, and the winner index to res_id.
  - res_valid is set to 1.
  - rr_ptr becomes winner+1, wrapping at NREQ.
- Drain event = res_valid & res_ready.
- Drain without accept: res_valid clears to 0. res_sum and res_id hold their last values.
- Drain and accept in the same cycle: the new result replaces the old one and res_valid stays 1. Sustained throughput is 1 op/cycle.
- In FULL with res_ready=0:
  - All req_ready bits are 0 and the result registers hold.
  - rr_ptr holds.
- No request is ever dropped, and no result is ever overwritten before it is consumed.
- Arithmetic: res_sum = a + b + cin, unsigned and exact across 33 bits.
- Requesters must hold valid and data stable until ready. req_ready depends only on req_valid, rr_ptr and the output state, never on req_a or req_b.
- Bits of req_valid at indices >= NREQ do not exist. Requester indices wrap modulo NREQ.

## Timing
- Reset values:
  - res_valid=0, res_sum=0, res_id=0, rr_ptr=0.
  - busy and req_ready follow the combinational inputs, so req_ready can be high in the first cycle after reset.
- Latency: a request accepted at rising edge k gives res_valid=1 with its result after edge k, one cycle.
- The adder sits between the operand mux and the result register. The critical path is rr-grant, then the 32-bit mux, then the CSA, then the register.
- Reset asserted mid-operation clears the pending result and rr_ptr immediately. The in-flight result is lost.

## Configuration
- CSA_ARB_OVF_EN defined:
  - Adds output port res_ovf (1 bit), registered with res_sum.
  - res_ovf is the signed two's-complement overflow: (a[31]==b[31]) & (sum[31]!=a[31]).
  - res_ovf resets to 0.
- CSA_ARB_OVF_EN undefined: the port and its register are absent, and behaviour is otherwise identical.

## Structure
- Shared package csa_arb_pkg holds:
  - CSA_W = 32.
  - SUM_W = 33.
  - The function clog2.
  - typedef state_t {EMPTY, FULL}.
- Sub-module rr_arbiter (parameter N) produces the one-hot grant and next pointer from req_valid and rr_ptr.
- The top level contains:
  - the operand mux;
  - one SquareRootCSA instance, port order (sout, in1, in2, c0);
  - the result register.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 with req_valid=4'b1111, then release.
  - Required response: during reset res_valid=0, res_sum=0, res_id=0. After release, req_ready=4'b0001; after one edge, res_id=0.
- Single add:
  - Stimulus: requester 2 sends a=32'hFFFF_FFFF, b=32'h1, cin=1.
  - Required response: one cycle later res_sum=33'h1_0000_0001, res_id=2.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, res_ready=1.
  - Required response: res_id sequence 0,1,2,3,0,1; exactly 1 result per cycle.
- Backpressure:
  - Stimulus: res_ready=0 for 3 cycles with requests pending.
  - Required response: req_ready=0, and res_sum/res_id are stable. When res_ready rises, the next winner is accepted in the same cycle.
- Simultaneous drain and accept:
  - Stimulus: FULL with result 33'h5; requester 1 sends a=7, b=8, cin=0; res_ready=1.
  - Required response: res_sum=33'hF on the next edge; res_valid never drops.
- Overflow (CSA_ARB_OVF_EN defined):
  - Stimulus: a=32'h7FFF_FFFF, b=32'h1, cin=0.
  - Required response: res_ovf=1, res_sum=33'h0_8000_0000.
